// File: rtl/srio_type9_pkg.sv
// Shared definitions for the SRIO Type 9 (data streaming) packer/unpacker pair.
// Holds the fixed header layout, the ftype constant, the unpacker FSM encoding
// and the helpers that turn a byte length into a beat count and a last-beat
// byte-enable mask.
package srio_type9_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    localparam int AXIS_USER_W = 32;
    localparam int BEAT_CNT_W  = 14;

    localparam logic [3:0] FTYPE_T9 = 4'b1001;

    // Header beat layout
    localparam int HDR_FTYPE_MSB = 55;
    localparam int HDR_FTYPE_LSB = 52;
    localparam int HDR_PRIO_MSB  = 46;
    localparam int HDR_PRIO_LSB  = 45;
    localparam int HDR_CRF_BIT   = 44;
    localparam int HDR_COS_MSB   = 43;
    localparam int HDR_COS_LSB   = 36;
    localparam int HDR_SID_MSB   = 31;
    localparam int HDR_SID_LSB   = 16;
    localparam int HDR_LEN_MSB   = 15;
    localparam int HDR_LEN_LSB   = 0;

    typedef enum logic [1:0] {
        ST_HDR     = 2'b00,
        ST_PAYLOAD = 2'b01,
        ST_DROP    = 2'b10
    } t9_state_e;

    // ceil(len/8); 14 bits so that len 65535 yields 8192
    function automatic logic [BEAT_CNT_W-1:0] t9_beats(input logic [15:0] len);
        return {1'b0, len[15:3]} + {13'd0, (len[2:0] != 3'd0)};
    endfunction

    // Byte enables of the final beat, low bytes first
    function automatic logic [AXIS_KEEP_W-1:0] t9_last_keep(input logic [15:0] len);
        logic [AXIS_KEEP_W-1:0] keep;
        if (len[2:0] == 3'd0) begin
            keep = 8'hFF;
        end else begin
            keep = (8'h01 << len[2:0]) - 8'h01;
        end
        return keep;
    endfunction

endpackage

// File: rtl/srio_axis_outreg.sv
// One-entry AXI-Stream output register (data, keep, last, user).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   srst         synchronous clear of the held entry
//   load         write the entry (only asserted while in_ready is high)
//   in_*         entry contents
//   in_ready     register can take a beat this cycle
//   out_ready    downstream handshake
//   out_*        registered AXI-Stream master outputs
module srio_axis_outreg
    import srio_type9_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   srst,
    input  logic                   load,
    input  logic [AXIS_DATA_W-1:0] in_data,
    input  logic [AXIS_KEEP_W-1:0] in_keep,
    input  logic                   in_last,
    input  logic [AXIS_USER_W-1:0] in_user,
    output logic                   in_ready,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [AXIS_DATA_W-1:0] out_data,
    output logic [AXIS_KEEP_W-1:0] out_keep,
    output logic                   out_last,
    output logic [AXIS_USER_W-1:0] out_user
);

    logic                   valid_q, valid_d;
    logic [AXIS_DATA_W-1:0] data_q, data_d;
    logic [AXIS_KEEP_W-1:0] keep_q, keep_d;
    logic                   last_q, last_d;
    logic [AXIS_USER_W-1:0] user_q, user_d;

    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;
    assign out_user  = user_q;

    // Next entry: clear, load, drain or hold
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        keep_d  = keep_q;
        last_d  = last_q;
        user_d  = user_q;
        if (srst) begin
            valid_d = 1'b0;
            data_d  = 64'd0;
            keep_d  = 8'd0;
            last_d  = 1'b0;
            user_d  = 32'd0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = in_data;
            keep_d  = in_keep;
            last_d  = in_last;
            user_d  = in_user;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= 64'd0;
            keep_q  <= 8'd0;
            last_q  <= 1'b0;
            user_q  <= 32'd0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            keep_q  <= keep_d;
            last_q  <= last_d;
            user_q  <= user_d;
        end
    end

endmodule

// File: rtl/srio_type9_unpack_logic.sv
// SRIO Type 9 receive unpacker. Parses the header beat of each packet on the
// S stream, discards non-Type-9 / filtered / malformed packets and forwards
// the payload on the M stream with byte-accurate TKEEP and TLAST.
// Ports:
//   AXIS_ACLK, AXIS_ARESETN        clock, asynchronous active-low reset
//   S_AXIS_*                       SRIO RX stream (header beat then payload)
//   M_AXIS_*                       payload stream, TUSER = packet srcdest
//   cmd                            [0] enable [1] soft reset [2] streamID filter [3] clear stats
//   filter_streamID                streamID accepted while the filter is on
//   stat_pkt/drop/err_cnt          saturating status counters
//   last_hdr                       header of the last forwarded packet
module srio_type9_unpack_logic
    import srio_type9_pkg::*;
(
    input  logic        AXIS_ACLK,
    input  logic        AXIS_ARESETN,
    input  logic        S_AXIS_TVALID,
    output logic        S_AXIS_TREADY,
    input  logic [63:0] S_AXIS_TDATA,
    input  logic        S_AXIS_TLAST,
    input  logic [31:0] S_AXIS_TUSER,
    output logic        M_AXIS_TVALID,
    input  logic        M_AXIS_TREADY,
    output logic [63:0] M_AXIS_TDATA,
    output logic [7:0]  M_AXIS_TKEEP,
    output logic        M_AXIS_TLAST,
    output logic [31:0] M_AXIS_TUSER,
    input  logic [31:0] cmd,
    input  logic [15:0] filter_streamID,
    output logic [31:0] stat_pkt_cnt,
    output logic [15:0] stat_drop_cnt,
    output logic [15:0] stat_err_cnt,
    output logic [63:0] last_hdr
);

    logic enable_s, srst_s, filt_en_s, clr_s;
    logic cmd_unused_s;
    assign enable_s     = cmd[0];
    assign srst_s       = cmd[1];
    assign filt_en_s    = cmd[2];
    assign clr_s        = cmd[3];
    assign cmd_unused_s = ^cmd[31:4];

    t9_state_e              state_q, state_d;
    logic                   run_q, run_d;
    logic [BEAT_CNT_W-1:0]  cnt_q, cnt_d;
    logic [BEAT_CNT_W-1:0]  beats_q, beats_d;
    logic [7:0]             keep_last_q, keep_last_d;
    logic [31:0]            srcdest_q, srcdest_d;
    logic [31:0]            pkt_cnt_q, pkt_cnt_d;
    logic [15:0]            drop_cnt_q, drop_cnt_d;
    logic [15:0]            err_cnt_q, err_cnt_d;
    logic [63:0]            last_hdr_q, last_hdr_d;

    logic                   s_ready_s, s_accept_s;
    logic                   ob_in_ready_s, ob_load_s, ob_last_s;
    logic [7:0]             ob_keep_s;
    logic                   inc_pkt_s, inc_drop_s, inc_err_s, hdr_take_s;
    logic [BEAT_CNT_W-1:0]  n_beat_s;

    logic [3:0]  ftype_s;
    logic [15:0] sid_s, len_s;
    logic        drop_hit_s, len_bad_s;

    assign ftype_s    = S_AXIS_TDATA[HDR_FTYPE_MSB:HDR_FTYPE_LSB];
    assign sid_s      = S_AXIS_TDATA[HDR_SID_MSB:HDR_SID_LSB];
    assign len_s      = S_AXIS_TDATA[HDR_LEN_MSB:HDR_LEN_LSB];
    assign drop_hit_s = (ftype_s != FTYPE_T9) || (filt_en_s && (sid_s != filter_streamID));
    // A header carrying TLAST has no payload at all, which is a framing error
    assign len_bad_s  = (len_s == 16'd0) || S_AXIS_TLAST;
    assign n_beat_s   = cnt_q + 14'd1;

    assign S_AXIS_TREADY = s_ready_s;
    assign s_accept_s    = S_AXIS_TVALID && s_ready_s;

    assign stat_pkt_cnt  = pkt_cnt_q;
    assign stat_drop_cnt = drop_cnt_q;
    assign stat_err_cnt  = err_cnt_q;
    assign last_hdr      = last_hdr_q;

    // Input ready per state; held low during soft reset so no beat is taken
    // while the FSM is being resynchronised, and low until the first edge
    // after reset release.
    always_comb begin
        s_ready_s = 1'b0;
        if (!run_q || srst_s) begin
            s_ready_s = 1'b0;
        end else begin
            case (state_q)
                ST_HDR:     s_ready_s = enable_s;
                ST_PAYLOAD: s_ready_s = ob_in_ready_s;
                ST_DROP:    s_ready_s = 1'b1;
                default:    s_ready_s = 1'b0;
            endcase
        end
    end

    // FSM next state, packet bookkeeping and output-register load decode
    always_comb begin
        state_d     = state_q;
        run_d       = 1'b1;
        cnt_d       = cnt_q;
        beats_d     = beats_q;
        keep_last_d = keep_last_q;
        srcdest_d   = srcdest_q;
        inc_pkt_s   = 1'b0;
        inc_drop_s  = 1'b0;
        inc_err_s   = 1'b0;
        hdr_take_s  = 1'b0;
        ob_load_s   = 1'b0;
        ob_last_s   = 1'b0;
        ob_keep_s   = 8'hFF;
        if (srst_s) begin
            case (state_q)
                ST_PAYLOAD: state_d = ST_DROP;
                default:    state_d = state_q;
            endcase
        end else if (s_accept_s) begin
            case (state_q)
                ST_HDR: begin
                    if (drop_hit_s) begin
                        inc_drop_s = 1'b1;
                        state_d    = S_AXIS_TLAST ? ST_HDR : ST_DROP;
                    end else if (len_bad_s) begin
                        inc_err_s = 1'b1;
                        state_d   = S_AXIS_TLAST ? ST_HDR : ST_DROP;
                    end else begin
                        hdr_take_s  = 1'b1;
                        beats_d     = t9_beats(len_s);
                        keep_last_d = t9_last_keep(len_s);
                        srcdest_d   = S_AXIS_TUSER;
                        cnt_d       = 14'd0;
                        state_d     = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    ob_load_s = 1'b1;
                    cnt_d     = n_beat_s;
                    if (n_beat_s == beats_q) begin
                        // Declared length reached: close the packet here and
                        // drop any surplus beats if the source keeps going.
                        ob_last_s = 1'b1;
                        ob_keep_s = keep_last_q;
                        inc_pkt_s = 1'b1;
                        if (S_AXIS_TLAST) begin
                            state_d = ST_HDR;
                        end else begin
                            inc_err_s = 1'b1;
                            state_d   = ST_DROP;
                        end
                    end else if (S_AXIS_TLAST) begin
                        ob_last_s = 1'b1;
                        ob_keep_s = 8'hFF;
                        inc_pkt_s = 1'b1;
                        inc_err_s = 1'b1;
                        state_d   = ST_HDR;
                    end else begin
                        ob_last_s = 1'b0;
                    end
                end
                ST_DROP: begin
                    state_d = S_AXIS_TLAST ? ST_HDR : ST_DROP;
                end
                default: begin
                    state_d = ST_HDR;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Saturating counters and last header; a clear beats a same-cycle update
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        err_cnt_d  = err_cnt_q;
        last_hdr_d = last_hdr_q;
        if (clr_s) begin
            pkt_cnt_d  = 32'd0;
            drop_cnt_d = 16'd0;
            err_cnt_d  = 16'd0;
            last_hdr_d = 64'd0;
        end else begin
            if (inc_pkt_s && (pkt_cnt_q != 32'hFFFF_FFFF)) begin
                pkt_cnt_d = pkt_cnt_q + 32'd1;
            end else begin
                pkt_cnt_d = pkt_cnt_q;
            end
            if (inc_drop_s && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
            if (inc_err_s && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (hdr_take_s) begin
                last_hdr_d = S_AXIS_TDATA;
            end else begin
                last_hdr_d = last_hdr_q;
            end
        end
    end

    // FSM and datapath state
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q     <= ST_HDR;
            run_q       <= 1'b0;
            cnt_q       <= 14'd0;
            beats_q     <= 14'd0;
            keep_last_q <= 8'd0;
            srcdest_q   <= 32'd0;
            pkt_cnt_q   <= 32'd0;
            drop_cnt_q  <= 16'd0;
            err_cnt_q   <= 16'd0;
            last_hdr_q  <= 64'd0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            cnt_q       <= cnt_d;
            beats_q     <= beats_d;
            keep_last_q <= keep_last_d;
            srcdest_q   <= srcdest_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_cnt_q   <= err_cnt_d;
            last_hdr_q  <= last_hdr_d;
        end
    end

    srio_axis_outreg u_outreg (
        .clk       (AXIS_ACLK),
        .rst_n     (AXIS_ARESETN),
        .srst      (srst_s),
        .load      (ob_load_s),
        .in_data   (S_AXIS_TDATA),
        .in_keep   (ob_keep_s),
        .in_last   (ob_last_s),
        .in_user   (srcdest_q),
        .in_ready  (ob_in_ready_s),
        .out_ready (M_AXIS_TREADY),
        .out_valid (M_AXIS_TVALID),
        .out_data  (M_AXIS_TDATA),
        .out_keep  (M_AXIS_TKEEP),
        .out_last  (M_AXIS_TLAST),
        .out_user  (M_AXIS_TUSER)
    );

endmodule
